img_frame_source: RTL and testbench
===================================

Name: img_frame_source

Overview:
- Frame-store playback source: holds one image in an internal simple-dual-port RAM, loaded through a pixel write port.
- Replays the image as a raster mat stream with configurable horizontal and vertical blanking.
- Master end of the mat stream. Feeds img_buffer, optical-flow stages and benches with repeatable frames in place of the sensor path.

Parameters:
- BUF_SIZE, 640*480, pixel capacity of the frame store.
- ROWS_BITS, 10, width of rows / row counters.
- COLS_BITS, 10, width of cols / column counters.
- DATA_BITS, 10, pixel width (TAPS=1, CH_DEPTH=1).
- USER_BITS, 1, mat user width; bit0 = frame start, upper bits 0.
- RAM_TYPE, "block", RAM primitive selection.
- ADDR_BITS, $clog2(BUF_SIZE), derived, frame-store address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- cke  in  1  pipeline clock enable; all state advances only when cke=1.
- enable  in  1  run request; sampled at frame boundaries.
- param_rows  in  ROWS_BITS  active rows per frame (>=1).
- param_cols  in  COLS_BITS  active columns per row (>=1).
- param_hblank  in  16  blank cycles after each row (0 allowed).
- param_vblank  in  16  idle cycles after each frame (0 allowed).
- wr_en  in  1  frame-store write strobe, independent of cke.
- wr_addr  in  ADDR_BITS  write address.
- wr_din  in  DATA_BITS  write data.
- busy  out  1  1 from frame start through end of that frame's vblank.
- m_rows  out  ROWS_BITS  latched row count.
- m_cols  out  COLS_BITS  latched column count.
- m_row_first  out  1  row 0 flag.
- m_row_last  out  1  last row flag.
- m_col_first  out  1  column 0 flag.
- m_col_last  out  1  last column flag.
- m_de  out  1  active pixel.
- m_data  out  DATA_BITS  pixel.
- m_user  out  USER_BITS  bit0=1 on first pixel of frame.
- m_valid  out  1  stream cycle valid.

Behaviour:
- Reset, asynchronous, takes effect immediately including mid-frame. All outputs 0, state IDLE, counters 0. Frame-store contents are not cleared and are retained.
- cke=0 freezes every register, including the RAM read enable and output register. Outputs hold.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: if enable=1, latch all param_* into shadow registers, set x=0, y=0, addr=0, and go to ACTIVE.
- ACTIVE: emits one pixel per cke cycle with de=1, valid=1, addr++.
  - At x=cols-1: go to HBLANK if hblank>0.
  - Otherwise, if y<rows-1, start the next row (y++, x=0).
  - Otherwise go to VBLANK, or straight to end-of-frame if vblank=0.
- HBLANK: valid=1, de=0, col_first=col_last=0. row_first/row_last are held for the current row. Lasts hblank cycles, then next row; after the last row, VBLANK.
- VBLANK: valid=0, de=0, lasts vblank cycles.
- End-of-frame (after VBLANK, or immediately if vblank=0):
  - enable=1: re-latch params and start ACTIVE for the next frame, with no gap cycle.
  - enable=0: go to IDLE.
- Deasserting enable mid-frame never truncates the frame. Params changed mid-frame take effect next frame only.
- Read address is a running counter from 0 that wraps to 0 when it reaches BUF_SIZE. Frames larger than the store repeat from address 0.
- Latency: generator cycle N drives the RAM address (stage 0), RAM read (stage 1), output register DOUT_REG (stage 2). m_* update on cke edge N+3. All sideband is delayed by the same 3 stages so data and flags stay aligned.
- Write/read collision on the same address in the same cycle is read-first: the old data is output.
- busy rises with the IDLE->ACTIVE transition and falls when returning to IDLE (generator side, not delayed).
- Cycles per frame = rows*(cols+hblank)+vblank. Valid cycles per frame = rows*(cols+hblank).

Test Plan:
- Load addr k = 10+k, k=0..5. Set rows=2, cols=3, hblank=1, vblank=2, enable=1 -> first m_valid 3 cycles after start.
  - Required output sequence (valid cycles): data 10,11,12 (de=1), then one de=0 cycle, then 13,14,15, then one de=0 cycle.
  - Flags: user0=1 only on data 10; col_last on 12 and 15; row_last on the second row; then 2 cycles valid=0; then the frame repeats.
- hblank=0, vblank=0, rows=2, cols=2 -> continuous de=1 stream 10,11,12,13,10,... with no gap cycles between frames.
- Toggle cke 1/0 alternately during a frame -> output sequence identical to the cke=1 run, with outputs held on cke=0 cycles.
- Drop enable at the 2nd pixel -> frame completes all 6 pixels plus vblank, then busy=0 and m_valid stays 0.
- Assert reset mid-ACTIVE -> all outputs 0 within the same cycle. Re-enable -> frame restarts at data 10, and the RAM contents are intact.
- BUF_SIZE=4, rows=2, cols=3 -> read addresses 0,1,2,3,0,1 (wrap at BUF_SIZE).
- Write addr 0 = 99 on the same edge it is read -> output shows old 10. The next frame shows 99.

Source files
------------

// File: rtl/img_frame_source.sv
// img_frame_source: frame-store playback source.
// One image is held in an internal simple-dual-port RAM, written through a
// free-running pixel write port.  A raster generator replays the stored
// image as a mat stream with programmable horizontal and vertical blanking.
// Data and all sideband flags share the same 3-stage pipeline:
// address register, RAM read register, output register.
module img_frame_source #(
  parameter int BUF_SIZE  = 640*480,
  parameter int ROWS_BITS = 10,
  parameter int COLS_BITS = 10,
  parameter int DATA_BITS = 10,
  parameter int USER_BITS = 1,
  parameter     RAM_TYPE  = "block",
  parameter int ADDR_BITS = $clog2(BUF_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 enable,
  input  logic [ROWS_BITS-1:0] param_rows,
  input  logic [COLS_BITS-1:0] param_cols,
  input  logic [15:0]          param_hblank,
  input  logic [15:0]          param_vblank,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_din,
  output logic                 busy,
  output logic [ROWS_BITS-1:0] m_rows,
  output logic [COLS_BITS-1:0] m_cols,
  output logic                 m_row_first,
  output logic                 m_row_last,
  output logic                 m_col_first,
  output logic                 m_col_last,
  output logic                 m_de,
  output logic [DATA_BITS-1:0] m_data,
  output logic [USER_BITS-1:0] m_user,
  output logic                 m_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_MAX = ADDR_BITS'(BUF_SIZE - 1);

  // Generator state and counters
  state_t               state;
  state_t               state_nxt;
  logic [COLS_BITS-1:0] x;
  logic [COLS_BITS-1:0] x_nxt;
  logic [ROWS_BITS-1:0] y;
  logic [ROWS_BITS-1:0] y_nxt;
  logic [15:0]          bcnt;
  logic [15:0]          bcnt_nxt;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic                 load_params;
  logic                 frame_end;

  // Per-frame shadow copies of the run parameters
  logic [ROWS_BITS-1:0] rows_s;
  logic [COLS_BITS-1:0] cols_s;
  logic [15:0]          hblank_s;
  logic [15:0]          vblank_s;

  // Position decode
  logic                 x_last;
  logic                 y_last;
  logic                 hb_last;
  logic                 vb_last;
  logic [ADDR_BITS-1:0] addr_inc;

  // Generator-side stream outputs (cycle N)
  logic gen_vld;
  logic gen_de;
  logic gen_sof;
  logic gen_rf;
  logic gen_rl;
  logic gen_cf;
  logic gen_cl;

  // Pipeline: {de, sof, row_first, row_last, col_first, col_last}
  logic                 vld_p0;
  logic [5:0]           side_p0;
  logic [ADDR_BITS-1:0] addr_p0;
  logic [ROWS_BITS-1:0] rows_p0;
  logic [COLS_BITS-1:0] cols_p0;
  logic                 vld_p1;
  logic [5:0]           side_p1;
  logic [DATA_BITS-1:0] rdata_p1;
  logic [ROWS_BITS-1:0] rows_p1;
  logic [COLS_BITS-1:0] cols_p1;

  assign x_last   = (x == cols_s - COLS_BITS'(1));
  assign y_last   = (y == rows_s - ROWS_BITS'(1));
  assign hb_last  = (bcnt == hblank_s - 16'd1);
  assign vb_last  = (bcnt == vblank_s - 16'd1);
  assign addr_inc = (addr == ADDR_MAX) ? '0 : addr + ADDR_BITS'(1);

  // Generator state register: advances only on enabled clock edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      x        <= '0;
      y        <= '0;
      bcnt     <= '0;
      addr     <= '0;
      rows_s   <= '0;
      cols_s   <= '0;
      hblank_s <= '0;
      vblank_s <= '0;
    end else if (cke) begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      bcnt  <= bcnt_nxt;
      addr  <= addr_nxt;
      if (load_params) begin
        rows_s   <= param_rows;
        cols_s   <= param_cols;
        hblank_s <= param_hblank;
        vblank_s <= param_vblank;
      end
    end
  end

  // Next-state and counter logic; a frame end with enable high restarts
  // ACTIVE directly so back-to-back frames have no gap cycle
  always_comb begin
    state_nxt   = state;
    x_nxt       = x;
    y_nxt       = y;
    bcnt_nxt    = bcnt;
    addr_nxt    = addr;
    load_params = 1'b0;
    frame_end   = 1'b0;
    case (state)
      S_IDLE: begin
        frame_end = 1'b1;
      end
      S_ACTIVE: begin
        addr_nxt = addr_inc;
        if (!x_last) begin
          x_nxt = x + COLS_BITS'(1);
        end else if (hblank_s != 16'd0) begin
          state_nxt = S_HBLANK;
          bcnt_nxt  = '0;
        end else if (!y_last) begin
          y_nxt = y + ROWS_BITS'(1);
          x_nxt = '0;
        end else if (vblank_s != 16'd0) begin
          state_nxt = S_VBLANK;
          bcnt_nxt  = '0;
        end else begin
          frame_end = 1'b1;
        end
      end
      S_HBLANK: begin
        if (!hb_last) begin
          bcnt_nxt = bcnt + 16'd1;
        end else if (!y_last) begin
          state_nxt = S_ACTIVE;
          y_nxt     = y + ROWS_BITS'(1);
          x_nxt     = '0;
        end else if (vblank_s != 16'd0) begin
          state_nxt = S_VBLANK;
          bcnt_nxt  = '0;
        end else begin
          frame_end = 1'b1;
        end
      end
      S_VBLANK: begin
        if (!vb_last) begin
          bcnt_nxt = bcnt + 16'd1;
        end else begin
          frame_end = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (frame_end) begin
      if (enable) begin
        load_params = 1'b1;
        state_nxt   = S_ACTIVE;
        x_nxt       = '0;
        y_nxt       = '0;
        addr_nxt    = '0;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  // Generator outputs decoded from the current state and position
  always_comb begin
    gen_vld = 1'b0;
    gen_de  = 1'b0;
    gen_sof = 1'b0;
    gen_rf  = 1'b0;
    gen_rl  = 1'b0;
    gen_cf  = 1'b0;
    gen_cl  = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_ACTIVE: begin
        gen_vld = 1'b1;
        gen_de  = 1'b1;
        gen_sof = (x == '0) && (y == '0);
        gen_rf  = (y == '0);
        gen_rl  = y_last;
        gen_cf  = (x == '0);
        gen_cl  = x_last;
      end
      S_HBLANK: begin
        gen_vld = 1'b1;
        gen_rf  = (y == '0);
        gen_rl  = y_last;
      end
      default: begin
        gen_vld = 1'b0;
      end
    endcase
  end

  // ---- stage 0: RAM address and sideband capture ----
  // Control half of stage 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      side_p0 <= '0;
    end else if (cke) begin
      vld_p0  <= gen_vld;
      side_p0 <= {gen_de, gen_sof, gen_rf, gen_rl, gen_cf, gen_cl};
    end
  end

  // Data half of stage 0
  always_ff @(posedge clk) begin
    if (cke) begin
      addr_p0 <= addr;
      rows_p0 <= rows_s;
      cols_p0 <= cols_s;
    end
  end

  // ---- stage 1: frame-store read ----
  // Control half of stage 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      side_p1 <= '0;
    end else if (cke) begin
      vld_p1  <= vld_p0;
      side_p1 <= side_p0;
    end
  end

  // Data half of stage 1 (frame geometry travels with the pixel)
  always_ff @(posedge clk) begin
    if (cke) begin
      rows_p1 <= rows_p0;
      cols_p1 <= cols_p0;
    end
  end

  // Frame store: write port is free-running, read port is gated by cke.
  // Separate non-blocking write and read give read-first on collisions.
  if (RAM_TYPE == "distributed") begin : g_lutram
    (* ram_style = "distributed" *) logic [DATA_BITS-1:0] mem [BUF_SIZE];

    // Pixel write port
    always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < (ADDR_BITS+1)'(BUF_SIZE))) mem[wr_addr] <= wr_din;
    end

    // Registered read port
    always_ff @(posedge clk) begin
      if (cke) rdata_p1 <= mem[addr_p0];
    end
  end else begin : g_bram
    (* ram_style = "block" *) logic [DATA_BITS-1:0] mem [BUF_SIZE];

    // Pixel write port
    always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < (ADDR_BITS+1)'(BUF_SIZE))) mem[wr_addr] <= wr_din;
    end

    // Registered read port
    always_ff @(posedge clk) begin
      if (cke) rdata_p1 <= mem[addr_p0];
    end
  end

  // ---- stage 2: output register ----
  // Output register; cleared immediately by reset so the stream goes quiet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid     <= 1'b0;
      m_de        <= 1'b0;
      m_user      <= '0;
      m_row_first <= 1'b0;
      m_row_last  <= 1'b0;
      m_col_first <= 1'b0;
      m_col_last  <= 1'b0;
      m_data      <= '0;
      m_rows      <= '0;
      m_cols      <= '0;
    end else if (cke) begin
      m_valid     <= vld_p1;
      m_de        <= side_p1[5];
      m_user      <= USER_BITS'(side_p1[4]);
      m_row_first <= side_p1[3];
      m_row_last  <= side_p1[2];
      m_col_first <= side_p1[1];
      m_col_last  <= side_p1[0];
      m_data      <= rdata_p1;
      m_rows      <= rows_p1;
      m_cols      <= cols_p1;
    end
  end

endmodule

// File: tb/tb_img_frame_source.sv
// Directed bench for img_frame_source: raster sequence with blanking,
// back-to-back frames, cke stalls, late enable drop, async reset,
// read-first collision and address wrap on a small frame store.
module tb_img_frame_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic        enable;
  logic        enable_w;
  logic [9:0]  param_rows;
  logic [9:0]  param_cols;
  logic [15:0] param_hblank;
  logic [15:0] param_vblank;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [9:0]  wr_din;
  logic        w_wr_en;
  logic [1:0]  w_wr_addr;
  logic [9:0]  w_wr_din;

  logic        busy;
  logic [9:0]  m_rows;
  logic [9:0]  m_cols;
  logic        m_row_first, m_row_last, m_col_first, m_col_last;
  logic        m_de, m_valid;
  logic [9:0]  m_data;
  logic [0:0]  m_user;

  logic        w_busy;
  logic [9:0]  w_m_rows;
  logic [9:0]  w_m_cols;
  logic        w_m_row_first, w_m_row_last, w_m_col_first, w_m_col_last;
  logic        w_m_de, w_m_valid;
  logic [9:0]  w_m_data;
  logic [0:0]  w_m_user;

  int checks   = 0;
  int failures = 0;
  int n_en     = 0;

  // {valid, de, user0, row_first, row_last, col_first, col_last, data[9:0]}
  logic [16:0] tab [0:13];
  logic [9:0]  wdat [0:6];

  always #5 clk = ~clk;

  img_frame_source dut (
    .clk(clk), .reset(reset), .cke(cke), .enable(enable),
    .param_rows(param_rows), .param_cols(param_cols),
    .param_hblank(param_hblank), .param_vblank(param_vblank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
    .busy(busy), .m_rows(m_rows), .m_cols(m_cols),
    .m_row_first(m_row_first), .m_row_last(m_row_last),
    .m_col_first(m_col_first), .m_col_last(m_col_last),
    .m_de(m_de), .m_data(m_data), .m_user(m_user), .m_valid(m_valid)
  );

  img_frame_source #(.BUF_SIZE(4)) dut_w (
    .clk(clk), .reset(reset), .cke(cke), .enable(enable_w),
    .param_rows(param_rows), .param_cols(param_cols),
    .param_hblank(param_hblank), .param_vblank(param_vblank),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_din(w_wr_din),
    .busy(w_busy), .m_rows(w_m_rows), .m_cols(w_m_cols),
    .m_row_first(w_m_row_first), .m_row_last(w_m_row_last),
    .m_col_first(w_m_col_first), .m_col_last(w_m_col_last),
    .m_de(w_m_de), .m_data(w_m_data), .m_user(w_m_user), .m_valid(w_m_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_main(input logic de_exp);
    return {15'd0, m_valid, m_de, m_user[0], m_row_first, m_row_last,
            m_col_first, m_col_last, (de_exp ? m_data : 10'd0)};
  endfunction

  function automatic logic [31:0] obs_w(input logic de_exp);
    return {15'd0, w_m_valid, w_m_de, w_m_user[0], w_m_row_first, w_m_row_last,
            w_m_col_first, w_m_col_last, (de_exp ? w_m_data : 10'd0)};
  endfunction

  task automatic load(input int a, input int v);
    wr_en   = 1'b1;
    wr_addr = 19'(a);
    wr_din  = 10'(v);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic set_params(input int r, input int c, input int hb, input int vb);
    param_rows   = 10'(r);
    param_cols   = 10'(c);
    param_hblank = 16'(hb);
    param_vblank = 16'(vb);
  endtask

  task automatic start_frame(input string tag);
    enable = 1'b1;
    cke    = 1'b1;
    tick();
    n_en = 0;
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic run_seq(input string tag, input int base, input int len,
                         input int edges, input bit toggle, input int drop_at);
    int idx;
    logic [16:0] ev;
    for (int e = 1; e <= edges; e++) begin
      cke = toggle ? ((e % 2) == 1) : 1'b1;
      if (e == drop_at) enable = 1'b0;
      tick();
      if (cke) n_en++;
      idx = n_en - 3;
      ev  = (idx < 0) ? 17'd0 : tab[base + (idx % len)];
      chk($sformatf("%s_%0d", tag, e), obs_main(ev[15]), {15'd0, ev});
    end
    cke = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick(); tick(); tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0]  = {7'b1111010, 10'd10};
    tab[1]  = {7'b1101000, 10'd11};
    tab[2]  = {7'b1101001, 10'd12};
    tab[3]  = {7'b1001000, 10'd0};
    tab[4]  = {7'b1100110, 10'd13};
    tab[5]  = {7'b1100100, 10'd14};
    tab[6]  = {7'b1100101, 10'd15};
    tab[7]  = {7'b1000100, 10'd0};
    tab[8]  = 17'd0;
    tab[9]  = 17'd0;
    tab[10] = {7'b1111010, 10'd10};
    tab[11] = {7'b1101001, 10'd11};
    tab[12] = {7'b1100110, 10'd12};
    tab[13] = {7'b1100101, 10'd13};
    wdat[0] = 10'd10; wdat[1] = 10'd11; wdat[2] = 10'd12; wdat[3] = 10'd0;
    wdat[4] = 10'd13; wdat[5] = 10'd10; wdat[6] = 10'd11;

    reset = 1'b1; cke = 1'b1; enable = 1'b0; enable_w = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_din = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_din = '0;
    set_params(2, 3, 1, 2);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_outs", {4'd0, busy, m_valid, m_de, m_user[0], m_row_first, m_row_last,
                       m_col_first, m_col_last, m_data, m_rows}, 32'd0);
    chk("reset_cols", {22'd0, m_cols}, 32'd0);

    for (int k = 0; k < 6; k++) load(k, 10 + k);
    for (int k = 0; k < 4; k++) begin
      w_wr_en = 1'b1; w_wr_addr = 2'(k); w_wr_din = 10'(10 + k);
      tick();
    end
    w_wr_en = 1'b0;

    // Two full frames with hblank=1, vblank=2
    set_params(2, 3, 1, 2);
    start_frame("basic");
    run_seq("basic", 0, 10, 23, 1'b0, 0);
    enable = 1'b0;
    wait_idle("basic");
    chk("basic_rows", {22'd0, m_rows}, 32'd2);
    chk("basic_cols", {22'd0, m_cols}, 32'd3);

    // No blanking: continuous stream across frame boundaries
    set_params(2, 2, 0, 0);
    start_frame("noblank");
    run_seq("noblank", 10, 4, 15, 1'b0, 0);
    enable = 1'b0;
    wait_idle("noblank");

    // Alternating cke: sequence unchanged, outputs hold on stalls
    set_params(2, 3, 1, 2);
    start_frame("stall");
    run_seq("stall", 0, 10, 40, 1'b1, 0);
    enable = 1'b0;
    wait_idle("stall");

    // Enable dropped during the 2nd pixel: frame still completes
    start_frame("drop");
    run_seq("drop", 0, 10, 12, 1'b0, 2);
    chk("drop_busy_low", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drop_quiet_%0d", i), obs_main(1'b0), 32'd0);
    end

    // Asynchronous reset mid-ACTIVE, then restart with RAM intact
    start_frame("rst");
    run_seq("rst", 0, 10, 5, 1'b0, 0);
    reset = 1'b1;
    #1;
    chk("rst_outs", {4'd0, busy, m_valid, m_de, m_user[0], m_row_first, m_row_last,
                     m_col_first, m_col_last, m_data, m_rows}, 32'd0);
    chk("rst_cols", {22'd0, m_cols}, 32'd0);
    tick();
    reset = 1'b0;
    enable = 1'b0;
    tick();
    start_frame("rerun");
    run_seq("rerun", 0, 10, 13, 1'b0, 0);
    enable = 1'b0;
    wait_idle("rerun");

    // Write to address 0 on the edge that reads it: old data, then new
    start_frame("coll");
    run_seq("coll", 0, 10, 1, 1'b0, 0);
    wr_en = 1'b1; wr_addr = '0; wr_din = 10'd99;
    run_seq("coll", 0, 10, 1, 1'b0, 0);
    wr_en = 1'b0;
    run_seq("coll", 0, 10, 10, 1'b0, 0);
    tick();
    chk("coll_next", obs_main(1'b1), {15'd0, 7'b1111010, 10'd99});
    enable = 1'b0;
    wait_idle("coll");

    // 4-entry store: six pixels read addresses 0,1,2,3,0,1
    set_params(2, 3, 1, 2);
    enable_w = 1'b1;
    tick();
    chk("wrap_busy", {31'd0, w_busy}, 32'd1);
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e >= 3) chk($sformatf("wrap_%0d", e - 3), obs_w(tab[e - 3][15]),
                      {15'd0, tab[e - 3][16:10], wdat[e - 3]});
    end
    enable_w = 1'b0;
    chk("wrap_geom", {12'd0, w_m_rows, w_m_cols}, {12'd0, 10'd2, 10'd3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
